// File: rtl/id_stage_pkg.sv
// Shared widths, opcode constants and bus layouts for the decode stage slice.
package id_stage_pkg;

   localparam int FS_TO_DS_BUS_WD = 64;
   localparam int DS_TO_ES_BUS_WD = 150;
   localparam int BR_BUS_WD       = 33;
   localparam int WS_TO_RF_BUS_WD = 38;

   localparam logic [16:0] OP_ADD_W  = 17'h00020;
   localparam logic [16:0] OP_SUB_W  = 17'h00022;
   localparam logic [16:0] OP_SLT    = 17'h00024;
   localparam logic [16:0] OP_SLTU   = 17'h00025;
   localparam logic [16:0] OP_NOR    = 17'h00028;
   localparam logic [16:0] OP_AND    = 17'h00029;
   localparam logic [16:0] OP_OR     = 17'h0002a;
   localparam logic [16:0] OP_XOR    = 17'h0002b;
   localparam logic [16:0] OP_SLLI_W = 17'h00081;
   localparam logic [16:0] OP_SRLI_W = 17'h00089;
   localparam logic [16:0] OP_SRAI_W = 17'h00091;
   localparam logic [9:0]  OP_ADDI_W = 10'h00a;
   localparam logic [9:0]  OP_LD_W   = 10'h0a2;
   localparam logic [9:0]  OP_ST_W   = 10'h0a6;
   localparam logic [5:0]  OP_JIRL   = 6'h13;
   localparam logic [5:0]  OP_B      = 6'h14;
   localparam logic [5:0]  OP_BL     = 6'h15;
   localparam logic [5:0]  OP_BEQ    = 6'h16;
   localparam logic [5:0]  OP_BNE    = 6'h17;
   localparam logic [6:0]  OP_LU12I  = 7'h0a;

   // Bit positions inside the one-hot alu_op field.
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_NOR,
      ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_sel_e;

   typedef struct packed {
      logic [11:0] alu_op;
      logic        load_op;
      logic        src1_is_pc;
      logic        src2_is_imm;
      logic        gr_we;
      logic        mem_we;
      logic [4:0]  dest;
      logic [31:0] imm;
      logic [31:0] rj_value;
      logic [31:0] rkd_value;
      logic [31:0] pc;
   } ds_to_es_t;

   function automatic logic [31:0] branchOffs16(input logic [15:0] offs);
      return {{14{offs[15]}}, offs, 2'b00};
   endfunction

   function automatic logic [31:0] branchOffs26(input logic [25:0] offs);
      return {{4{offs[25]}}, offs, 2'b00};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Pipeline-facing signals of the decode stage: fetch, execute, writeback and hazard inputs.
interface id_stage_if;
   import id_stage_pkg::*;

   logic                       es_allowin;
   logic                       ds_allowin;
   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
   logic                       ds_to_es_valid;
   logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
   logic [BR_BUS_WD-1:0]       br_bus;
   logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
   logic [4:0]                 es_dest;
   logic [4:0]                 ms_dest;
   logic [4:0]                 ws_dest;

   modport master (
      output es_allowin, fs_to_ds_valid, fs_to_ds_bus, ws_to_rf_bus,
             es_dest, ms_dest, ws_dest,
      input  ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
   );

   modport slave (
      input  es_allowin, fs_to_ds_valid, fs_to_ds_bus, ws_to_rf_bus,
             es_dest, ms_dest, ws_dest,
      output ds_allowin, ds_to_es_valid, ds_to_es_bus, br_bus
   );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
module id_stage_regfile
   import id_stage_pkg::*;
(
   input  logic        clk,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr1_i,
   output logic [31:0] rdata1_o,
   input  logic [4:0]  raddr2_i,
   output logic [31:0] rdata2_o
);
   logic [31:0] regs_q [32];

   // Writes to r0 are dropped so the zero register never needs a reset.
   always_ff @(posedge clk) begin
      if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage: holds one instruction from fetch, reads operands, blocks on RAW hazards, resolves branches.
module id_stage
   import id_stage_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   id_stage_if.slave pipe
);
   logic        ds_valid_q, ds_valid_d;
   logic [31:0] ds_inst_q, ds_pc_q;
   logic        dsReadyGo, dsAllowin;
   logic [4:0]  rd, rj, rk, readAddr2;
   logic [31:0] rjValue, rkdValue, brOffs, brTarget;
   logic        instAdd, instSub, instSlt, instSltu, instNor, instAnd, instOr, instXor;
   logic        instSlli, instSrli, instSrai, instAddi, instLd, instSt;
   logic        instJirl, instB, instBl, instBeq, instBne, instLu12i;
   logic        is3r, isShift, srcRj, srcRd, srcRk, grWeRaw, brTaken;
   logic [4:0]  dest;
   ds_to_es_t   esBus;

   assign dsAllowin  = !ds_valid_q || (dsReadyGo && pipe.es_allowin);
   assign ds_valid_d = dsAllowin ? pipe.fs_to_ds_valid : ds_valid_q;

   always_ff @(posedge clk) begin
      if (reset) ds_valid_q <= 1'b0;
      else       ds_valid_q <= ds_valid_d;
   end

   // The held instruction is only replaced when the stage actually accepts from fetch.
   always_ff @(posedge clk) begin
      if (pipe.fs_to_ds_valid && dsAllowin) begin
         ds_inst_q <= pipe.fs_to_ds_bus[63:32];
         ds_pc_q   <= pipe.fs_to_ds_bus[31:0];
      end
   end

   assign rd = ds_inst_q[4:0];
   assign rj = ds_inst_q[9:5];
   assign rk = ds_inst_q[14:10];

   assign instAdd   = ds_inst_q[31:15] == OP_ADD_W;
   assign instSub   = ds_inst_q[31:15] == OP_SUB_W;
   assign instSlt   = ds_inst_q[31:15] == OP_SLT;
   assign instSltu  = ds_inst_q[31:15] == OP_SLTU;
   assign instNor   = ds_inst_q[31:15] == OP_NOR;
   assign instAnd   = ds_inst_q[31:15] == OP_AND;
   assign instOr    = ds_inst_q[31:15] == OP_OR;
   assign instXor   = ds_inst_q[31:15] == OP_XOR;
   assign instSlli  = ds_inst_q[31:15] == OP_SLLI_W;
   assign instSrli  = ds_inst_q[31:15] == OP_SRLI_W;
   assign instSrai  = ds_inst_q[31:15] == OP_SRAI_W;
   assign instAddi  = ds_inst_q[31:22] == OP_ADDI_W;
   assign instLd    = ds_inst_q[31:22] == OP_LD_W;
   assign instSt    = ds_inst_q[31:22] == OP_ST_W;
   assign instJirl  = ds_inst_q[31:26] == OP_JIRL;
   assign instB     = ds_inst_q[31:26] == OP_B;
   assign instBl    = ds_inst_q[31:26] == OP_BL;
   assign instBeq   = ds_inst_q[31:26] == OP_BEQ;
   assign instBne   = ds_inst_q[31:26] == OP_BNE;
   assign instLu12i = ds_inst_q[31:25] == OP_LU12I;

   assign is3r    = instAdd | instSub | instSlt | instSltu | instNor | instAnd | instOr | instXor;
   assign isShift = instSlli | instSrli | instSrai;
   assign srcRj   = is3r | isShift | instAddi | instLd | instSt | instJirl | instBeq | instBne;
   assign srcRd   = instBeq | instBne | instSt;
   assign srcRk   = is3r;
   assign readAddr2 = srcRd ? rd : rk;

   id_stage_regfile u_regfile (
      .clk      (clk),
      .we_i     (pipe.ws_to_rf_bus[37]),
      .waddr_i  (pipe.ws_to_rf_bus[36:32]),
      .wdata_i  (pipe.ws_to_rf_bus[31:0]),
      .raddr1_i (rj),
      .rdata1_o (rjValue),
      .raddr2_i (readAddr2),
      .rdata2_o (rkdValue)
   );

   // Only sources the instruction really reads can block it; r0 never does.
   function automatic logic inFlight(input logic [4:0] r);
      return (r != 5'd0) && ((r == pipe.es_dest) || (r == pipe.ms_dest) || (r == pipe.ws_dest));
   endfunction

   assign dsReadyGo = !((srcRj && inFlight(rj)) || ((srcRk || srcRd) && inFlight(readAddr2)));

   assign dest    = instBl ? 5'd1 : rd;
   assign grWeRaw = is3r | isShift | instAddi | instLd | instJirl | instBl | instLu12i;

   always_comb begin
      esBus                     = '0;
      esBus.alu_op[ALU_ADD]     = instAdd | instAddi | instLd | instSt | instJirl | instBl;
      esBus.alu_op[ALU_SUB]     = instSub;
      esBus.alu_op[ALU_SLT]     = instSlt;
      esBus.alu_op[ALU_SLTU]    = instSltu;
      esBus.alu_op[ALU_AND]     = instAnd;
      esBus.alu_op[ALU_NOR]     = instNor;
      esBus.alu_op[ALU_OR]      = instOr;
      esBus.alu_op[ALU_XOR]     = instXor;
      esBus.alu_op[ALU_SLL]     = instSlli;
      esBus.alu_op[ALU_SRL]     = instSrli;
      esBus.alu_op[ALU_SRA]     = instSrai;
      esBus.alu_op[ALU_LUI]     = instLu12i;
      esBus.load_op             = instLd;
      esBus.src1_is_pc          = instBl | instJirl;
      esBus.src2_is_imm         = isShift | instAddi | instLd | instSt | instLu12i | instBl | instJirl;
      esBus.gr_we               = grWeRaw && (dest != 5'd0);
      esBus.mem_we              = instSt;
      esBus.dest                = dest;
      if (instAddi || instLd || instSt) esBus.imm = {{20{ds_inst_q[21]}}, ds_inst_q[21:10]};
      else if (isShift)                 esBus.imm = {27'd0, ds_inst_q[14:10]};
      else if (instLu12i)               esBus.imm = {ds_inst_q[24:5], 12'd0};
      else if (instBl || instJirl)      esBus.imm = 32'd4;
      esBus.rj_value            = rjValue;
      esBus.rkd_value           = rkdValue;
      esBus.pc                  = ds_pc_q;
   end

   assign brOffs   = (instB || instBl) ? branchOffs26({ds_inst_q[9:0], ds_inst_q[25:10]})
                                       : branchOffs16(ds_inst_q[25:10]);
   assign brTarget = (instJirl ? rjValue : ds_pc_q) + brOffs;
   assign brTaken  = ds_valid_q && dsReadyGo &&
                     (instB || instBl || instJirl ||
                      (instBeq && (rjValue == rkdValue)) ||
                      (instBne && (rjValue != rkdValue)));

   assign pipe.ds_allowin     = dsAllowin;
   assign pipe.ds_to_es_valid = ds_valid_q && dsReadyGo;
   assign pipe.ds_to_es_bus   = esBus;
   assign pipe.br_bus         = {brTaken, brTarget};

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage blocking pipeline; sits directly downstream of the fetch stage and upstream of execute.
- Accepts {inst, pc} from fetch and decodes the LA32 lab instruction subset.
- Reads operands from an internal register file, which is written by the writeback bus.
- Stalls on read-after-write hazards (blocking only, no forwarding), resolves branches, and returns the branch bus to fetch.

Parameters:
- none; all widths come from the shared header.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- es_allowin  in  1  execute stage can accept
- ds_allowin  out  1  decode can accept from fetch
- fs_to_ds_valid  in  1  fetch output valid
- fs_to_ds_bus  in  64  {inst[31:0], pc[31:0]}
- ds_to_es_valid  out  1  decode output valid
- ds_to_es_bus  out  150  {alu_op[11:0], load_op, src1_is_pc, src2_is_imm, gr_we, mem_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0]}
- br_bus  out  33  {br_taken, br_target[31:0]}
- ws_to_rf_bus  in  38  {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
- es_dest, ms_dest, ws_dest  in  5 each  destination register of the valid, writing instruction in that stage; 0 = none

Behaviour:
- Reset:
  - Synchronous, active-high signal reset; clock clk.
  - ds_valid <= 0, so ds_to_es_valid = 0 and br_taken = 0 after reset.
  - ds_inst and ds_pc are not reset.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - When ds_allowin: ds_valid <= fs_to_ds_valid.
  - When fs_to_ds_valid && ds_allowin: latch the bus.
  - ds_to_es_valid = ds_valid && ds_ready_go.
- Decode:
  - Subset: add.w/sub.w/slt/sltu/nor/and/or/xor (op[31:15] = 0x00020, 22, 24, 25, 28, 29, 2a, 2b).
  - slli.w/srli.w/srai.w (0x00081, 89, 91).
  - addi.w/ld.w/st.w (op[31:22] = 0x00a, 0a2, 0a6).
  - jirl/b/bl/beq/bne (op[31:26] = 0x13–0x17).
  - lu12i.w (op[31:25] = 0x0a).
  - Unlisted encodings decode as NOP: gr_we = 0, mem_we = 0, no branch.
  - alu_op is one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - load_op = ld.w. mem_we = st.w.
  - gr_we is 0 for st/b/beq/bne. gr_we is also 0 when dest = r0.
- Immediates:
  - si12 sign-extended for addi/ld/st.
  - ui5 zero-extended for shifts.
  - {si20, 12'b0} for lu12i.
- Link:
  - bl writes r1; jirl writes rd.
  - Both set src1_is_pc = 1, src2_is_imm = 1, imm = 4, alu add.
- Sources:
  - rj is read by all except b/bl/lu12i.
  - Second read port uses rk for 3R ops; it uses rd for beq/bne/st.w.
- Hazard:
  - ds_ready_go = 0 if any used source register (non-zero) equals es_dest, ms_dest or ws_dest.
  - Otherwise ds_ready_go = 1. Unused sources never block.
- Branch:
  - offs16 sign-extended then <<2 for beq/bne/jirl.
  - offs26 = {inst[9:0], inst[25:10]} sign-extended then <<2 for b/bl.
  - Target is pc + offs, except jirl: rj_value + offs.
  - br_taken = ds_valid && ds_ready_go && (b | bl | jirl | (beq && rj == rd) | (bne && rj != rd)).
  - br_taken holds while stalled on es_allowin.
  - Fetch squashes its current instruction whenever br_taken = 1.
- Register file:
  - 32x32, 2 asynchronous reads, 1 synchronous write from ws_to_rf_bus.
  - r0 always reads 0; writes to r0 are ignored.
  - No write-to-read bypass is needed, because ws_dest blocks the read.
- Simultaneous events:
  - Stall with new fetch data: the held instruction is kept and the bus is not relatched.
  - Reset during stall: the stage is cleared next edge.

Decomposition:
- Shared header gets FS_TO_DS_BUS_WD = 64, DS_TO_ES_BUS_WD = 150, BR_BUS_WD = 33, WS_TO_RF_BUS_WD = 38, and the opcode constants.
- One sub-module: regfile (2R1W).

Test Plan:
1. Reset, then fs_to_ds_valid = 1 with inst addi.w r1, r0, 5 (0x02801401) at pc 0x1c000000, es_allowin = 1 -> next cycle:
   - ds_to_es_valid = 1
   - alu_op = add, src2_is_imm = 1, imm = 5, dest = 1, gr_we = 1
2. add.w r3, r1, r2 with es_dest = 1 -> ds_ready_go = 0, ds_allowin = 0, ds_to_es_valid = 0.
   - es_dest moves to ms_dest: still blocked.
   - All three dest inputs = 0: issues next cycle.
3. beq r1, r2, +8 at pc 0x1c000010 with rf r1 = r2 = 7 -> br_bus = {1, 0x1c000018}.
   - Same with r2 = 8 -> br_taken = 0.
4. bl +0x100 at pc 0x1c000020 -> br_target = 0x1c000120, dest = 1, src1_is_pc = 1, imm = 4.
   - jirl r0, r1, 0 with r1 = 0x1c000024 -> br_target = 0x1c000024, gr_we = 0.
5. es_allowin = 0 while a valid instruction is held -> ds_allowin = 0, the bus stays stable, and br_taken stays asserted for a held branch.
6. Writeback writes r5 = 0xdeadbeef, then r0 = 1 -> later reads give r5 = 0xdeadbeef and r0 = 0.
   - Assert reset mid-stall -> ds_to_es_valid = 0 the next cycle.
